mdu_iter: RTL and testbench

- Iterative RV32M multiply/divide unit in the EX stage, alongside alu.
- Takes the same rs1/rs2 operand pair that alu receives.
- Produces a 32-bit result that the EX result mux selects instead of the alu C output when the decoded instruction is an M-extension op.
- Multi-cycle, with a start/busy/done handshake that the hazard unit uses to stall the pipeline.

---
 rtl/mdu_pkg.sv | 35 +++
 rtl/mdu_if.sv | 16 +
 rtl/mdu_div_step.sv | 20 ++
 rtl/mdu_iter.sv | 149 ++++++++++++++
 tb/tb_mdu_iter.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings and constants for the iterative RV32M multiply/divide unit.
package mdu_pkg;

    localparam int XLEN = 32;

    // Operation select encodings (funct3 of the M-extension opcodes)
    localparam logic [2:0] MDU_MUL    = 3'b000;
    localparam logic [2:0] MDU_MULH   = 3'b001;
    localparam logic [2:0] MDU_MULHSU = 3'b010;
    localparam logic [2:0] MDU_MULHU  = 3'b011;
    localparam logic [2:0] MDU_DIV    = 3'b100;
    localparam logic [2:0] MDU_DIVU   = 3'b101;
    localparam logic [2:0] MDU_REM    = 3'b110;
    localparam logic [2:0] MDU_REMU   = 3'b111;

    // Control FSM states
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    // Special-case result constants
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    // rs1 is interpreted as two's complement for these ops
    function automatic logic op_a_signed(input logic [2:0] op);
        return (op == MDU_MULH) || (op == MDU_MULHSU) || (op == MDU_DIV) || (op == MDU_REM);
    endfunction

    // rs2 is interpreted as two's complement for these ops
    function automatic logic op_b_signed(input logic [2:0] op);
        return (op == MDU_MULH) || (op == MDU_DIV) || (op == MDU_REM);
    endfunction

endpackage

// File: rtl/mdu_if.sv
// Request/response bundle between the EX stage and the multiply/divide unit.
interface mdu_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic            flush;
    logic [2:0]      MDUOp;
    logic [XLEN-1:0] A;
    logic [XLEN-1:0] B;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] C;

    modport master (output start, flush, MDUOp, A, B, input busy, done, C);
    modport slave  (input start, flush, MDUOp, A, B, output busy, done, C);
endinterface

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module mdu_div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN:0]   rem_in,
    input  logic [XLEN-1:0] divisor,
    input  logic            dividend_bit,
    output logic [XLEN:0]   rem_out,
    output logic            q_bit
);
    logic [XLEN+1:0] diff;

    // Remainder stays below the divisor, so the shifted value fits XLEN+1 bits;
    // the extra top bit of diff is the borrow of the trial subtraction.
    always_comb begin
        diff    = {rem_in, dividend_bit} - {2'b00, divisor};
        q_bit   = ~diff[XLEN+1];
        rem_out = q_bit ? diff[XLEN:0] : {rem_in[XLEN-1:0], dividend_bit};
    end
endmodule

// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit: 32 shift-add or restoring-divide
// iterations on operand magnitudes, then a sign/special-case fix-up cycle.
module mdu_iter #(
    parameter int XLEN  = 32,
    parameter int ITERS = 32
) (
    input  logic clk,
    input  logic rst_n,
    mdu_if.slave bus
);
    import mdu_pkg::*;

    logic [1:0]        state;
    logic [2:0]        op;
    logic [5:0]        cnt;
    logic [2*XLEN-1:0] acc;
    logic [XLEN:0]     rem;
    logic [XLEN-1:0]   opb;
    logic              neg_res;
    logic              neg_rem;
    logic              b_zero;
    logic              ovf;
    logic [XLEN-1:0]   c_q;
    logic              done_q;

    logic              sa;
    logic              sb;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic [XLEN-1:0]   mul_add;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     step_rem;
    logic              step_q;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quot;
    logic [XLEN-1:0]   remv;
    logic [XLEN-1:0]   result;

    function automatic logic [XLEN-1:0] neg_w(input logic [XLEN-1:0] v, input logic en);
        logic signed [XLEN-1:0] sv;
        sv = v;
        return en ? -sv : sv;
    endfunction

    function automatic logic [2*XLEN-1:0] neg_dw(input logic [2*XLEN-1:0] v, input logic en);
        logic signed [2*XLEN-1:0] sv;
        sv = v;
        return en ? -sv : sv;
    endfunction

    mdu_div_step #(.XLEN(XLEN)) u_step (
        .rem_in       (rem),
        .divisor      (opb),
        .dividend_bit (acc[XLEN-1]),
        .rem_out      (step_rem),
        .q_bit        (step_q)
    );

    // Operand magnitudes and sign flags derived from the live request
    always_comb begin
        sa    = op_a_signed(bus.MDUOp) & bus.A[XLEN-1];
        sb    = op_b_signed(bus.MDUOp) & bus.B[XLEN-1];
        a_mag = neg_w(bus.A, sa);
        b_mag = neg_w(bus.B, sb);
    end

    // Shift-add partial sum; the multiplier sits in acc low half and drains out LSB-first
    always_comb begin
        mul_add = acc[0] ? opb : '0;
        mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, mul_add};
    end

    // Fix-up: sign correction and result select. REM by zero needs no override:
    // the remainder holds |A| and takes the sign of A, which reproduces A.
    always_comb begin
        prod = neg_dw(acc, neg_res);
        quot = neg_w(acc[XLEN-1:0], neg_res);
        remv = neg_w(rem[XLEN-1:0], neg_rem);
        case (op)
            MDU_MUL:                        result = prod[XLEN-1:0];
            MDU_MULH, MDU_MULHSU, MDU_MULHU: result = prod[2*XLEN-1:XLEN];
            MDU_DIV, MDU_DIVU:              result = b_zero ? ALL_ONES : (ovf ? INT_MIN : quot);
            default:                        result = ovf ? '0 : remv;
        endcase
    end

    // Control FSM and iteration datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            op      <= '0;
            cnt     <= '0;
            acc     <= '0;
            rem     <= '0;
            opb     <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            b_zero  <= 1'b0;
            ovf     <= 1'b0;
            c_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.flush) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (bus.start) begin
                            op      <= bus.MDUOp;
                            acc     <= {{XLEN{1'b0}}, a_mag};
                            opb     <= b_mag;
                            rem     <= '0;
                            cnt     <= '0;
                            neg_res <= (sa ^ sb) & (~bus.MDUOp[2] | (|bus.B));
                            neg_rem <= sa;
                            b_zero  <= (bus.B == '0);
                            ovf     <= bus.MDUOp[2] & op_a_signed(bus.MDUOp) &
                                       (bus.A == INT_MIN) & (bus.B == ALL_ONES);
                            state   <= S_CALC;
                        end
                    end
                    S_CALC: begin
                        if (op[2]) begin
                            rem            <= step_rem;
                            acc[XLEN-1:0]  <= {acc[XLEN-2:0], step_q};
                        end else begin
                            acc <= {mul_sum, acc[XLEN-1:1]};
                        end
                        cnt <= cnt + 6'd1;
                        if (cnt == 6'(ITERS - 1)) begin
                            state <= S_FIX;
                        end
                    end
                    S_FIX: begin
                        c_q    <= result;
                        done_q <= 1'b1;
                        state  <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.busy = (state != S_IDLE);
    assign bus.done = done_q;
    assign bus.C    = c_q;
endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter: vector table plus handshake/reset sequences.
module tb_mdu_iter;
    import mdu_pkg::*;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    mdu_if bus ();

    mdu_iter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // Issue one op; inj_at >= 0 re-asserts start with other operands before that edge.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int inj_at, output logic [31:0] c, output int lat,
                         output logic hs_ok, output logic done_at_start);
        int   n;
        logic got;
        @(negedge clk);
        done_at_start = bus.done;
        bus.MDUOp = op;
        bus.A     = a;
        bus.B     = b;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.A     = ~a;
        bus.B     = ~b;
        bus.MDUOp = ~op;
        hs_ok = (bus.busy === 1'b1) && (bus.done === 1'b0);
        got = 1'b0;
        lat = -1;
        c   = '0;
        n   = 0;
        while (!got && n < 60) begin
            if (n == inj_at) begin
                bus.start = 1'b1;
                bus.MDUOp = MDU_DIV;
                bus.A     = 32'd3;
                bus.B     = 32'd5;
            end
            @(posedge clk);
            #1;
            n++;
            bus.start = 1'b0;
            if (bus.done === 1'b1) begin
                got = 1'b1;
                lat = n;
                c   = bus.C;
                if (bus.busy !== 1'b0) hs_ok = 1'b0;
            end else if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
                hs_ok = 1'b0;
            end
        end
    endtask

    initial begin
        vec_t        vecs[16];
        logic [31:0] c;
        logic [31:0] prev;
        int          lat;
        logic        hs_ok;
        logic        das;
        logic        seen_done;

        checks = 0;
        errors = 0;

        vecs[0]  = '{"mul_7x6",      MDU_MUL,    32'd7,        32'd6,        32'h0000002A};
        vecs[1]  = '{"mulh_m1m1",    MDU_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
        vecs[2]  = '{"mulhu_m1m1",   MDU_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
        vecs[3]  = '{"mulhsu_m1x2",  MDU_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF};
        vecs[4]  = '{"div_m7_2",     MDU_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD};
        vecs[5]  = '{"rem_m7_2",     MDU_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF};
        vecs[6]  = '{"divu_100_7",   MDU_DIVU,   32'd100,      32'd7,        32'd14};
        vecs[7]  = '{"remu_100_7",   MDU_REMU,   32'd100,      32'd7,        32'd2};
        vecs[8]  = '{"divu_by0",     MDU_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF};
        vecs[9]  = '{"rem_by0",      MDU_REM,    32'd5,        32'd0,        32'd5};
        vecs[10] = '{"div_ovf",      MDU_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000};
        vecs[11] = '{"rem_ovf",      MDU_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000};
        vecs[12] = '{"div_by0",      MDU_DIV,    32'd5,        32'd0,        32'hFFFFFFFF};
        vecs[13] = '{"rem_m7_by0",   MDU_REM,    32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9};
        vecs[14] = '{"div_7_m2",     MDU_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD};
        vecs[15] = '{"mulhu_big",    MDU_MULHU,  32'h80000000, 32'd4,        32'h00000002};

        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.MDUOp = '0;
        bus.A     = '0;
        bus.B     = '0;
        rst_n     = 1'b0;

        // Reset state
        @(posedge clk);
        #1;
        chk("reset_busy", {31'b0, bus.busy}, 32'd0);
        chk("reset_done", {31'b0, bus.done}, 32'd0);
        chk("reset_C", bus.C, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven functional vectors
        for (int i = 0; i < 16; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, -1, c, lat, hs_ok, das);
            chk({vecs[i].name, "_C"}, c, vecs[i].exp);
            chk({vecs[i].name, "_lat"}, 32'(lat), 32'd33);
            chk({vecs[i].name, "_hs"}, {31'b0, hs_ok}, 32'd1);
        end

        // start re-asserted mid-operation is ignored
        do_op(MDU_MUL, 32'd7, 32'd6, 9, c, lat, hs_ok, das);
        chk("restart_C", c, 32'h0000002A);
        chk("restart_lat", 32'(lat), 32'd33);
        @(posedge clk);
        #1;
        chk("restart_no_second_op", {31'b0, bus.busy}, 32'd0);

        // flush at cycle 15
        prev = bus.C;
        @(negedge clk);
        bus.MDUOp = MDU_DIVU;
        bus.A     = 32'd100;
        bus.B     = 32'd7;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        chk("flush_busy", {31'b0, bus.busy}, 32'd0);
        chk("flush_done", {31'b0, bus.done}, 32'd0);
        seen_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1 || bus.busy === 1'b1) seen_done = 1'b1;
        end
        chk("flush_no_done", {31'b0, seen_done}, 32'd0);
        chk("flush_C_kept", bus.C, prev);

        // flush wins over start in the same cycle
        @(negedge clk);
        bus.MDUOp = MDU_MUL;
        bus.A     = 32'd1;
        bus.B     = 32'd1;
        bus.start = 1'b1;
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        chk("flush_prio_busy", {31'b0, bus.busy}, 32'd0);

        // Back-to-back: start raised during the done cycle
        do_op(MDU_MUL, 32'd9, 32'd9, -1, c, lat, hs_ok, das);
        chk("b2b_first_C", c, 32'd81);
        do_op(MDU_REMU, 32'd100, 32'd7, -1, c, lat, hs_ok, das);
        chk("b2b_start_in_done", {31'b0, das}, 32'd1);
        chk("b2b_second_C", c, 32'd2);
        chk("b2b_second_lat", 32'(lat), 32'd33);
        chk("b2b_second_hs", {31'b0, hs_ok}, 32'd1);

        // Asynchronous reset mid-CALC
        @(negedge clk);
        bus.MDUOp = MDU_MUL;
        bus.A     = 32'd7;
        bus.B     = 32'd6;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_busy", {31'b0, bus.busy}, 32'd0);
        chk("async_rst_done", {31'b0, bus.done}, 32'd0);
        chk("async_rst_C", bus.C, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(MDU_MUL, 32'd3, 32'd5, -1, c, lat, hs_ok, das);
        chk("post_rst_C", c, 32'd15);
        chk("post_rst_lat", 32'(lat), 32'd33);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
